// File: rtl/fan_tach_meter.sv
// Fan tachometer period meter: synchronizes and deglitches the tach pin, then counts
// 1 us ticks between rising edges and flags a stalled fan on timeout.
module fan_tach_meter #(
  parameter int unsigned TICK_DIV = 100,
  parameter int unsigned CNT_W    = 20,
  parameter int unsigned TIMEOUT  = 1000000,
  parameter int unsigned DEB_LEN  = 4
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_enable,
  input  logic             i_tach,
  output logic [CNT_W-1:0] o_period,
  output logic             o_valid,
  output logic             o_stall
);

  localparam int unsigned PreW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DebW = $clog2(DEB_LEN + 1);
  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);
  localparam logic [PreW-1:0]  PreLast    = PreW'(TICK_DIV - 1);
  localparam logic [DebW-1:0]  DebLast    = DebW'(DEB_LEN - 1);

  typedef enum logic [1:0] {StIdle, StArm, StMeasure} state_e;

  state_e           state_q, state_d;
  logic             sync1_q, sync2_q;
  logic             filt_q, filt_d, filt_dly_q;
  logic [DebW-1:0]  deb_q, deb_d;
  logic             rise_q;
  logic [PreW-1:0]  pre_q, pre_d, pre_run;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             stall_q, stall_d;
  logic             tick;

  // Filtered level flips only after DEB_LEN consecutive differing samples.
  always_comb begin
    filt_d = filt_q;
    deb_d  = '0;
    if (sync2_q != filt_q) begin
      if (deb_q == DebLast) begin
        filt_d = ~filt_q;
      end else begin
        deb_d = deb_q + 1'b1;
      end
    end
  end

  assign tick    = (pre_q == PreLast);
  assign pre_run = tick ? '0 : pre_q + 1'b1;
  // Tick landing in the edge cycle is included so a period of P clocks reads floor(P/TICK_DIV).
  assign cnt_inc = (tick && (cnt_q != TimeoutCnt)) ? cnt_q + 1'b1 : cnt_q;

  always_comb begin
    state_d  = state_q;
    pre_d    = pre_run;
    cnt_d    = cnt_inc;
    period_d = period_q;
    valid_d  = 1'b0;
    stall_d  = stall_q;
    if (!i_enable) begin
      state_d = StIdle;
      pre_d   = '0;
      cnt_d   = '0;
      stall_d = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          pre_d   = '0;
          cnt_d   = '0;
          state_d = StArm;
        end
        // Prescaler keeps running while armed so the arm-phase timeout can elapse.
        StArm: begin
          if (rise_q) begin
            pre_d   = '0;
            cnt_d   = '0;
            state_d = StMeasure;
          end else if (cnt_q == TimeoutCnt) begin
            stall_d = 1'b1;
            cnt_d   = '0;
          end
        end
        StMeasure: begin
          if (rise_q) begin
            period_d = cnt_inc;
            valid_d  = 1'b1;
            stall_d  = 1'b0;
            pre_d    = '0;
            cnt_d    = '0;
          end else if (cnt_q == TimeoutCnt) begin
            stall_d  = 1'b1;
            period_d = '0;
            pre_d    = '0;
            cnt_d    = '0;
            state_d  = StArm;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= StIdle;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      filt_q     <= 1'b1;
      filt_dly_q <= 1'b1;
      deb_q      <= '0;
      rise_q     <= 1'b0;
      pre_q      <= '0;
      cnt_q      <= '0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      stall_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= i_tach;
      sync2_q    <= sync1_q;
      filt_q     <= filt_d;
      filt_dly_q <= filt_q;
      deb_q      <= deb_d;
      rise_q     <= filt_q & ~filt_dly_q;
      pre_q      <= pre_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      valid_q    <= valid_d;
      stall_q    <= stall_d;
    end
  end

  assign o_period = period_q;
  assign o_valid  = valid_q;
  assign o_stall  = stall_q;

endmodule

// File: tb/tb_fan_tach_meter.sv
// Self-checking bench for fan_tach_meter: randomized tach periods against an arithmetic
// model (period = floor(P / TICK_DIV), valid 1 + 3 + DEB_LEN cycles after the rise is set).
module tb_fan_tach_meter;

  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned CNT_W    = 12;
  localparam int unsigned TIMEOUT  = 1000;
  localparam int unsigned DEB_LEN  = 4;
  localparam int unsigned LAT      = 1 + 3 + DEB_LEN;

  logic             i_clk = 1'b0;
  logic             i_reset_n;
  logic             i_enable;
  logic             i_tach;
  logic [CNT_W-1:0] o_period;
  logic             o_valid;
  logic             o_stall;

  fan_tach_meter #(
    .TICK_DIV(TICK_DIV),
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT),
    .DEB_LEN (DEB_LEN)
  ) dut (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_enable (i_enable),
    .i_tach   (i_tach),
    .o_period (o_period),
    .o_valid  (o_valid),
    .o_stall  (o_stall)
  );

  always #5 i_clk = ~i_clk;

  int unsigned      cyc = 0;
  int unsigned      checks = 0;
  int unsigned      errors = 0;
  logic [CNT_W-1:0] v_per[$];
  int unsigned      v_stamp[$];
  int unsigned      dbl_valid = 0;
  int unsigned      stall_rises = 0;
  int unsigned      stall_stamp = 0;
  logic             prev_v = 1'b0;
  logic             prev_s = 1'b0;
  int unsigned      last_rise = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    if (o_valid) begin
      v_per.push_back(o_period);
      v_stamp.push_back(cyc);
    end
    if (o_valid && prev_v) dbl_valid <= dbl_valid + 1;
    if (o_stall && !prev_s) begin
      stall_rises <= stall_rises + 1;
      stall_stamp <= cyc;
    end
    prev_v <= o_valid;
    prev_s <= o_stall;
  end

  task automatic step(input int unsigned n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // Low for lo cycles, then high for hi cycles; t_r is the cycle the rise was driven.
  task automatic pulse(input int unsigned lo, input int unsigned hi, output int unsigned t_r);
    i_tach = 1'b0;
    step(lo);
    i_tach = 1'b1;
    t_r = cyc;
    step(hi);
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0;
    i_enable  = 1'b0;
    i_tach    = 1'b1;
    @(negedge i_clk);
    checks++; if (o_period !== '0) begin errors++; $display("FAIL reset_period got %0d want 0", o_period); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", o_valid); end
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", o_stall); end
    step(3);
    i_reset_n = 1'b1;
    step(2);
  endtask

  task automatic test_random();
    int unsigned t_prev, t_now, lo, hi;
    int unsigned exp_per[$];
    int unsigned exp_stamp[$];
    v_per.delete();
    v_stamp.delete();
    i_enable = 1'b1;
    step(2);
    pulse(20, 40, t_prev);
    for (int k = 0; k < 8; k++) begin
      lo = $urandom_range(600, 8);
      hi = $urandom_range(600, 8);
      pulse(lo, hi, t_now);
      exp_per.push_back((t_now - t_prev) / TICK_DIV);
      exp_stamp.push_back(t_now + LAT);
      t_prev = t_now;
    end
    step(10);
    last_rise = t_prev;
    checks++;
    if (v_per.size() != exp_per.size()) begin
      errors++;
      $display("FAIL rand_count got %0d want %0d", v_per.size(), exp_per.size());
    end
    for (int k = 0; k < exp_per.size() && k < v_per.size(); k++) begin
      checks++;
      if (32'(v_per[k]) !== exp_per[k]) begin
        errors++;
        $display("FAIL rand_period[%0d] got %0d want %0d", k, v_per[k], exp_per[k]);
      end
      checks++;
      if (v_stamp[k] !== exp_stamp[k]) begin
        errors++;
        $display("FAIL rand_latency[%0d] got cycle %0d want %0d", k, v_stamp[k], exp_stamp[k]);
      end
    end
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL rand_stall got %b want 0", o_stall); end
  endtask

  task automatic test_glitch();
    int unsigned t;
    v_per.delete();
    v_stamp.delete();
    i_tach = 1'b0;
    step(20);
    for (int g = 1; g <= 3; g++) begin
      i_tach = 1'b1;
      step(g);
      i_tach = 1'b0;
      step(12);
    end
    i_tach = 1'b1;
    t = cyc;
    step(20);
    checks++;
    if (v_per.size() != 1) begin
      errors++;
      $display("FAIL glitch_count got %0d want 1", v_per.size());
    end else begin
      checks++;
      if (32'(v_per[0]) !== (t - last_rise) / TICK_DIV) begin
        errors++;
        $display("FAIL glitch_period got %0d want %0d", v_per[0], (t - last_rise) / TICK_DIV);
      end
      checks++;
      if (v_stamp[0] !== t + LAT) begin
        errors++;
        $display("FAIL glitch_latency got cycle %0d want %0d", v_stamp[0], t + LAT);
      end
    end
    last_rise = t;
  endtask

  task automatic test_stall();
    int unsigned vst, sr, t1, t2;
    v_per.delete();
    v_stamp.delete();
    vst = last_rise + LAT;
    sr  = stall_rises;
    while (cyc < vst + TIMEOUT * TICK_DIV - 20) step(1);
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL stall_early got %b want 0", o_stall); end
    step(40);
    checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL stall_set got %b want 1", o_stall); end
    checks++; if (o_period !== '0) begin errors++; $display("FAIL stall_period got %0d want 0", o_period); end
    checks++; if (v_per.size() != 0) begin errors++; $display("FAIL stall_novalid got %0d want 0", v_per.size()); end
    checks++;
    if (stall_rises != sr + 1 || stall_stamp + 2 < vst + TIMEOUT * TICK_DIV ||
        stall_stamp > vst + TIMEOUT * TICK_DIV + 3) begin
      errors++;
      $display("FAIL stall_time got cycle %0d want about %0d", stall_stamp, vst + TIMEOUT * TICK_DIV);
    end
    pulse(10, 20, t1);
    pulse(500 * TICK_DIV - 20, 20, t2);
    checks++;
    if (v_per.size() != 1) begin
      errors++;
      $display("FAIL relock_count got %0d want 1", v_per.size());
    end else begin
      checks++;
      if (32'(v_per[0]) !== (t2 - t1) / TICK_DIV) begin
        errors++;
        $display("FAIL relock_period got %0d want %0d", v_per[0], (t2 - t1) / TICK_DIV);
      end
    end
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL relock_stall got %b want 0", o_stall); end
    last_rise = t2;
  endtask

  task automatic test_edge_at_timeout();
    int unsigned t, sr;
    v_per.delete();
    v_stamp.delete();
    sr = stall_rises;
    pulse(TIMEOUT * TICK_DIV + 1 - 20, 20, t);
    checks++;
    if (v_per.size() != 1) begin
      errors++;
      $display("FAIL edge_to_count got %0d want 1", v_per.size());
    end else begin
      checks++;
      if (32'(v_per[0]) !== TIMEOUT) begin
        errors++;
        $display("FAIL edge_to_period got %0d want %0d", v_per[0], TIMEOUT);
      end
    end
    checks++;
    if (stall_rises != sr || o_stall !== 1'b0) begin
      errors++;
      $display("FAIL edge_to_stall got %0d rises want %0d", stall_rises, sr);
    end
    last_rise = t;
  endtask

  task automatic test_enable_drop();
    int unsigned tx, ta, tb;
    v_per.delete();
    v_stamp.delete();
    step(200);
    i_enable = 1'b0;
    step(1);
    checks++; if (o_period !== CNT_W'(TIMEOUT)) begin errors++; $display("FAIL dis_hold got %0d want %0d", o_period, TIMEOUT); end
    pulse(30, 30, tx);
    step(10);
    checks++; if (v_per.size() != 0) begin errors++; $display("FAIL dis_novalid got %0d want 0", v_per.size()); end
    checks++; if (o_period !== CNT_W'(TIMEOUT)) begin errors++; $display("FAIL dis_hold2 got %0d want %0d", o_period, TIMEOUT); end
    i_enable = 1'b1;
    step(2);
    pulse(20, 30, ta);
    pulse(40, 30, tb);
    checks++;
    if (v_per.size() != 1) begin
      errors++;
      $display("FAIL reen_count got %0d want 1", v_per.size());
    end else begin
      checks++;
      if (32'(v_per[0]) !== (tb - ta) / TICK_DIV) begin
        errors++;
        $display("FAIL reen_period got %0d want %0d", v_per[0], (tb - ta) / TICK_DIV);
      end
    end
    step(TIMEOUT * TICK_DIV + 20);
    checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL dis_stall_pre got %b want 1", o_stall); end
    i_enable = 1'b0;
    step(1);
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL dis_stall_clr got %b want 0", o_stall); end
  endtask

  task automatic test_async_reset();
    int unsigned ta, tb;
    i_enable = 1'b1;
    step(2);
    pulse(20, 30, ta);
    pulse(60, 30, tb);
    step(50);
    checks++;
    if (32'(o_period) !== (tb - ta) / TICK_DIV) begin
      errors++;
      $display("FAIL pre_rst_period got %0d want %0d", o_period, (tb - ta) / TICK_DIV);
    end
    v_per.delete();
    v_stamp.delete();
    @(posedge i_clk);
    #3;
    i_reset_n = 1'b0;
    #1;
    checks++; if (o_period !== '0) begin errors++; $display("FAIL arst_period got %0d want 0", o_period); end
    checks++; if (o_valid !== 1'b0 || o_stall !== 1'b0) begin errors++; $display("FAIL arst_flags got %b%b want 00", o_valid, o_stall); end
    step(3);
    i_reset_n = 1'b1;
    step(2);
    pulse(20, 30, ta);
    pulse(100, 30, tb);
    checks++;
    if (v_per.size() != 1) begin
      errors++;
      $display("FAIL fresh_count got %0d want 1", v_per.size());
    end else begin
      checks++;
      if (32'(v_per[0]) !== (tb - ta) / TICK_DIV || v_stamp[0] !== tb + LAT) begin
        errors++;
        $display("FAIL fresh_period got %0d at %0d want %0d at %0d", v_per[0], v_stamp[0],
                 (tb - ta) / TICK_DIV, tb + LAT);
      end
    end
    checks++; if (dbl_valid != 0) begin errors++; $display("FAIL valid_width got %0d long pulses want 0", dbl_valid); end
  endtask

  initial begin
    test_reset();
    test_random();
    test_glitch();
    test_stall();
    test_edge_at_timeout();
    test_enable_drop();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
